csr_regfile: RTL

- Control/status register file at the far end of the writeback-stage CSR/exception interface.
- Serves CSR reads/masked writes and latches exception and ertn side effects.
- Runs the constant timer and produces the interrupt request, exception entry and ertn return target for the fetch stage.
- Single clock domain; all state updates on the rising edge.

---
 rtl/csr_regfile_pkg.sv | 49 ++++
 rtl/csr_regfile_if.sv | 40 ++++
 rtl/csr_regfile_timer.sv | 45 ++++
 rtl/csr_regfile.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/csr_regfile_pkg.sv
// csr_regfile_pkg: shared CSR numbers, field constants, exception codes and the
// masked-write helper used by the CSR register file and its testbench.
package csr_regfile_pkg;

   typedef logic [13:0] csr_num_t;

   // CSR numbers
   localparam csr_num_t CsrCrmd   = 14'h000;
   localparam csr_num_t CsrPrmd   = 14'h001;
   localparam csr_num_t CsrEcfg   = 14'h004;
   localparam csr_num_t CsrEstat  = 14'h005;
   localparam csr_num_t CsrEra    = 14'h006;
   localparam csr_num_t CsrBadv   = 14'h007;
   localparam csr_num_t CsrEentry = 14'h00C;
   localparam csr_num_t CsrSave0  = 14'h030;
   localparam csr_num_t CsrSave1  = 14'h031;
   localparam csr_num_t CsrSave2  = 14'h032;
   localparam csr_num_t CsrSave3  = 14'h033;
   localparam csr_num_t CsrTid    = 14'h040;
   localparam csr_num_t CsrTcfg   = 14'h041;
   localparam csr_num_t CsrTval   = 14'h042;
   localparam csr_num_t CsrTiclr  = 14'h044;

   // ESTAT.IS bit positions
   localparam int unsigned IsTimerBit = 11;
   localparam int unsigned IsIpiBit   = 12;

   // ECFG.LIE implemented bits (bit 10 does not exist)
   localparam logic [12:0] LieMask = 13'h1BFF;

   // Exception codes
   localparam logic [5:0] EcodeInt = 6'h00;
   localparam logic [5:0] EcodeAde = 6'h08;
   localparam logic [5:0] EcodeAle = 6'h09;
   localparam logic [5:0] EcodeSys = 6'h0B;
   localparam logic [5:0] EcodeBrk = 6'h0C;
   localparam logic [5:0] EcodeIne = 6'h0D;

   // Exception subcodes
   localparam logic [8:0] EsubcodeAdef = 9'h000;
   localparam logic [8:0] EsubcodeAdem = 9'h001;

   function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                             input logic [31:0] wvalue,
                                             input logic [31:0] wmask);
      return (wvalue & wmask) | (old_val & ~wmask);
   endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// csr_regfile_if: writeback-stage CSR/exception bus plus interrupt inputs and
// fetch-stage redirect outputs.
//   master: drives CSR read/write, commit info, interrupt lines
//   slave : returns read data, has_int, ex_entry, ertn_entry
interface csr_regfile_if;
   import csr_regfile_pkg::*;

   logic        csr_re;
   csr_num_t    csr_num;
   logic [31:0] csr_rvalue;
   logic        csr_we;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;
   logic        wb_ex;
   logic        ertn_flush;
   logic [31:0] wb_pc;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_vaddr;
   logic [7:0]  hw_int_in;
   logic        ipi_int_in;
   logic        has_int;
   logic [31:0] ex_entry;
   logic [31:0] ertn_entry;

   modport master (
      output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
             wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
             hw_int_in, ipi_int_in,
      input  csr_rvalue, has_int, ex_entry, ertn_entry
   );

   modport slave (
      input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
             wb_ex, ertn_flush, wb_pc, wb_ecode, wb_esubcode, wb_vaddr,
             hw_int_in, ipi_int_in,
      output csr_rvalue, has_int, ex_entry, ertn_entry
   );

endinterface

// File: rtl/csr_regfile_timer.sv
// csr_regfile_timer: constant timer counter behind TCFG/TVAL.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_tcfg_we              : TCFG write committed this cycle
//   i_tcfg_next_initval    : InitVal field of the TCFG value being written
//   i_en, i_periodic       : current TCFG.En / TCFG.Periodic
//   i_initval              : current TCFG.InitVal (periodic reload)
//   o_cnt                  : counter value (shown as TVAL)
//   o_expire               : high in the cycle the counter expires (sets TI)
module csr_regfile_timer #(
   parameter int unsigned TIMER_W = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_tcfg_we,
   input  logic [TIMER_W-3:0] i_tcfg_next_initval,
   input  logic               i_en,
   input  logic               i_periodic,
   input  logic [TIMER_W-3:0] i_initval,
   output logic [TIMER_W-1:0] o_cnt,
   output logic               o_expire
);

   // All-ones marks a one-shot timer that has already expired
   localparam logic [TIMER_W-1:0] CntHalt = '1;

   logic [TIMER_W-1:0] r_cnt;

   assign o_cnt    = r_cnt;
   assign o_expire = ~i_tcfg_we & i_en & (r_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= CntHalt;
      end else if (i_tcfg_we) begin
         r_cnt <= {i_tcfg_next_initval, 2'b00};
      end else if (i_en && (r_cnt != CntHalt)) begin
         if (r_cnt == '0) begin
            r_cnt <= i_periodic ? {i_initval, 2'b00} : CntHalt;
         end else begin
            r_cnt <= r_cnt - TIMER_W'(1);
         end
      end
   end

endmodule

// File: rtl/csr_regfile.sv
// csr_regfile: control/status register file at the writeback-stage CSR and
// exception interface. Serves combinational CSR reads and masked writes,
// latches exception/ertn side effects, samples interrupt lines, runs the
// constant timer and drives has_int, ex_entry (EENTRY) and ertn_entry (ERA).
//   clk : clock
//   rst : synchronous active-high reset
//   bus : csr_regfile_if slave modport (CSR bus, commit info, interrupts)
module csr_regfile
   import csr_regfile_pkg::*;
#(
   parameter int unsigned TIMER_W = 32
) (
   input logic           clk,
   input logic           rst,
   csr_regfile_if.slave  bus
);

   logic [1:0]         r_crmd_plv;
   logic               r_crmd_ie;
   logic               r_crmd_da;
   logic               r_crmd_pg;
   logic [1:0]         r_crmd_datf;
   logic [1:0]         r_crmd_datm;
   logic [1:0]         r_prmd_pplv;
   logic               r_prmd_pie;
   logic [12:0]        r_ecfg_lie;
   logic [12:0]        r_estat_is;
   logic [5:0]         r_estat_ecode;
   logic [8:0]         r_estat_esubcode;
   logic [31:0]        r_era;
   logic [31:0]        r_badv;
   logic [25:0]        r_eentry_va;
   logic [31:0]        r_save [4];
   logic [31:0]        r_tid;
   logic [TIMER_W-1:0] r_tcfg;

   logic [TIMER_W-1:0] w_cnt;
   logic               w_expire;
   logic               w_sw_we;
   logic               w_tcfg_we;
   logic               w_ticlr;
   logic [31:0]        w_old;
   logic [31:0]        w_new;

   // Field-assembled view of csr_num; also the "old" value for masked writes
   always_comb begin
      w_old = '0;
      case (bus.csr_num)
         CsrCrmd:   w_old = {23'b0, r_crmd_datm, r_crmd_datf, r_crmd_pg, r_crmd_da,
                             r_crmd_ie, r_crmd_plv};
         CsrPrmd:   w_old = {29'b0, r_prmd_pie, r_prmd_pplv};
         CsrEcfg:   w_old = {19'b0, r_ecfg_lie};
         CsrEstat:  w_old = {1'b0, r_estat_esubcode, r_estat_ecode, 3'b000, r_estat_is};
         CsrEra:    w_old = r_era;
         CsrBadv:   w_old = r_badv;
         CsrEentry: w_old = {r_eentry_va, 6'b0};
         CsrSave0:  w_old = r_save[0];
         CsrSave1:  w_old = r_save[1];
         CsrSave2:  w_old = r_save[2];
         CsrSave3:  w_old = r_save[3];
         CsrTid:    w_old = r_tid;
         CsrTcfg:   w_old = 32'(r_tcfg);
         CsrTval:   w_old = 32'(w_cnt);
         default:   w_old = '0;
      endcase
   end

   assign w_new          = csr_merge(w_old, bus.csr_wvalue, bus.csr_wmask);
   // Software writes lose to a same-cycle exception or ertn commit
   assign w_sw_we        = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
   assign w_tcfg_we      = w_sw_we & (bus.csr_num == CsrTcfg);
   // TICLR reads 0, so the merged bit 0 is exactly the masked CLR bit
   assign w_ticlr        = w_sw_we & (bus.csr_num == CsrTiclr) & w_new[0];

   assign bus.csr_rvalue = bus.csr_re ? w_old : '0;
   assign bus.has_int    = r_crmd_ie & (|(r_estat_is & r_ecfg_lie));
   assign bus.ex_entry   = {r_eentry_va, 6'b0};
   assign bus.ertn_entry = r_era;

   csr_regfile_timer #(
      .TIMER_W (TIMER_W)
   ) u_timer (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_tcfg_we           (w_tcfg_we),
      .i_tcfg_next_initval (w_new[TIMER_W-1:2]),
      .i_en                (r_tcfg[0]),
      .i_periodic          (r_tcfg[1]),
      .i_initval           (r_tcfg[TIMER_W-1:2]),
      .o_cnt               (w_cnt),
      .o_expire            (w_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_crmd_plv       <= '0;
         r_crmd_ie        <= 1'b0;
         r_crmd_da        <= 1'b1;
         r_crmd_pg        <= 1'b0;
         r_crmd_datf      <= '0;
         r_crmd_datm      <= '0;
         r_prmd_pplv      <= '0;
         r_prmd_pie       <= 1'b0;
         r_ecfg_lie       <= '0;
         r_estat_is       <= '0;
         r_estat_ecode    <= '0;
         r_estat_esubcode <= '0;
         r_era            <= '0;
         r_badv           <= '0;
         r_eentry_va      <= '0;
         for (int i = 0; i < 4; i++) r_save[i] <= '0;
         r_tid            <= '0;
         r_tcfg           <= '0;
      end else begin
         // Interrupt lines are sampled regardless of commits
         r_estat_is[9:2]      <= bus.hw_int_in;
         r_estat_is[IsIpiBit] <= bus.ipi_int_in;
         // Timer expiry wins over a same-cycle TICLR
         if (w_expire) begin
            r_estat_is[IsTimerBit] <= 1'b1;
         end else if (w_ticlr) begin
            r_estat_is[IsTimerBit] <= 1'b0;
         end

         if (bus.wb_ex) begin
            r_prmd_pplv      <= r_crmd_plv;
            r_prmd_pie       <= r_crmd_ie;
            r_crmd_plv       <= '0;
            r_crmd_ie        <= 1'b0;
            r_estat_ecode    <= bus.wb_ecode;
            r_estat_esubcode <= bus.wb_esubcode;
            r_era            <= bus.wb_pc;
            if ((bus.wb_ecode == EcodeAde) || (bus.wb_ecode == EcodeAle)) begin
               r_badv <= bus.wb_vaddr;
            end
         end else if (bus.ertn_flush) begin
            r_crmd_plv <= r_prmd_pplv;
            r_crmd_ie  <= r_prmd_pie;
         end else if (bus.csr_we) begin
            case (bus.csr_num)
               CsrCrmd: begin
                  r_crmd_plv  <= w_new[1:0];
                  r_crmd_ie   <= w_new[2];
                  r_crmd_da   <= w_new[3];
                  r_crmd_pg   <= w_new[4];
                  r_crmd_datf <= w_new[6:5];
                  r_crmd_datm <= w_new[8:7];
               end
               CsrPrmd: begin
                  r_prmd_pplv <= w_new[1:0];
                  r_prmd_pie  <= w_new[2];
               end
               CsrEcfg:   r_ecfg_lie      <= w_new[12:0] & LieMask;
               CsrEstat:  r_estat_is[1:0] <= w_new[1:0];
               CsrEra:    r_era           <= w_new;
               CsrBadv:   r_badv          <= w_new;
               CsrEentry: r_eentry_va     <= w_new[31:6];
               CsrSave0:  r_save[0]       <= w_new;
               CsrSave1:  r_save[1]       <= w_new;
               CsrSave2:  r_save[2]       <= w_new;
               CsrSave3:  r_save[3]       <= w_new;
               CsrTid:    r_tid           <= w_new;
               CsrTcfg:   r_tcfg          <= w_new[TIMER_W-1:0];
               default: ;
            endcase
         end
      end
   end

endmodule
